bus_datapath: RTL and testbench
===============================

// Module: bus_datapath
// PURPOSE
//   32-bit single-bus CPU datapath: 16 GPRs, PC, IR, HI/LO, Y, 64-bit Z, MAR, MDR,
//   inport and C-immediate sources, all sharing one tri-state-free muxed bus.
//   The control unit drives one-hot *_out / *_in strobes plus alu_op each cycle.
//   Sits between the control FSM and memory.
// PARAMETERS
//   (none) -- data width fixed at 32, register count fixed at 16.
// PORTS
//   clk         in   1   rising-edge clock
//   reset_n     in   1   synchronous, active-HIGH reset (clears every register)
//   gpr_in      in   16  bit i loads R[i] from bus
//   gpr_out     in   16  bit i drives R[i] onto bus
//   hi_in/lo_in in   1   load HI / LO from bus
//   hi_out/lo_out in 1   drive HI / LO onto bus
//   pc_in, pc_out in 1   load / drive PC
//   ir_in       in   1   load IR from bus
//   z_in        in   1   load 64-bit Z from ALU result
//   z_high_out, z_low_out in 1  drive Z[63:32] / Z[31:0]
//   inport_out  in   1   drive INPORT register (resets to 0; no load path here)
//   c_out       in   1   drive C = sign-extended IR[18:0]
//   y_in        in   1   load Y from bus
//   mar_in      in   1   load MAR from bus
//   mdr_in      in   1   load MDR (source chosen by read)
//   mdr_out     in   1   drive MDR
//   read        in   1   1: MDR source = m_data_in; 0: MDR source = bus
//   m_data_in   in   32  memory read data
//   alu_op      in   4   ALU operation select
//   inc_pc      in   1   overrides ALU: Z[31:0] = bus + 1, Z[63:32] = 0
//   bus_data    out  32  current bus value (combinational)
// BEHAVIOUR
//   - Reset (reset_n=1 at posedge): all registers incl. R0..R15, PC, IR, HI, LO, Y,
//     Z, MAR, MDR, INPORT -> 0. Loads are ignored during reset.
//   - Bus: combinational mux. Priority if >1 source asserted: R0..R15 (low index
//     first), HI, LO, Z_high, Z_low, PC, MDR, INPORT, C. No source -> 32'h0.
//   - Every register loads on posedge clk when its *_in is 1; holds otherwise.
//     Same-cycle read-modify-write is legal (old value on bus, new value after edge).
//   - ALU is combinational: A = Y, B = bus; Z captures result at the edge of the
//     z_in cycle (1-cycle latency from operand on bus to Z valid).
//   - alu_op: 0 AND, 1 OR, 2 ADD, 3 SUB(A-B), 4 SHR logical A>>B[4:0], 5 SHL,
//     6 ROR, 7 ROL, 8 MUL, 9 DIV, 10 NEG(-B), 11 NOT(~B), 12-15 -> 0.
//   - Single-word ops: Z[31:0]=result, Z[63:32]=0; ADD/SUB wrap modulo 2^32.
//   - MUL: signed 32x32 -> Z = 64-bit product (HI part in Z[63:32]).
//   - DIV: signed, truncate toward zero; Z[31:0]=quotient, Z[63:32]=remainder
//     (remainder sign = dividend sign). B=0 -> quotient 32'hFFFFFFFF,
//     remainder = A. 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
//   - inc_pc=1 takes precedence over alu_op.
//   - R0 is an ordinary register in this block (no hardwired zero).
// STRUCTURE
//   - Shared package: ALU opcode constants (ALU_AND..ALU_NOT), data width constant.
//   - One sub-module: alu (combinational, 32-bit A/B, 4-bit op, inc flag, 64-bit out).
//   - Register file as 16-entry array with per-entry enables; rest inline.
// TESTING
//   - Reset: assert reset_n 1 cycle -> bus_data=0 with every *_out asserted singly.
//   - MDR load: read=1,mdr_in=1,m_data_in=0x24; next cycle mdr_out=1,gpr_in[2]=1
//     -> R2=0x24; gpr_out[2]=1 shows bus_data=0x24.
//   - PC increment: PC=0, pc_out+inc_pc+z_in+alu_op=ADD, then z_low_out+pc_in -> PC=1.
//   - DIV: R2=0x24, R4=0x22; Y<=R2; R4 on bus, alu_op=9, z_in; z_low_out->LO,
//     z_high_out->HI -> LO=1, HI=2. Also B=0 -> LO=0xFFFFFFFF, HI=A.
//   - MUL: Y=0xFFFFFFFE, B=3 -> Z=0xFFFFFFFF_FFFFFFFA; SUB 5-7 -> Z_low=0xFFFFFFFE.
//   - IR/C: load IR=0x7920_0000 -> c_out gives 0; IR[18:0]=0x7FFFF -> 0xFFFFFFFF.

Source files
------------

// File: rtl/bus_datapath_pkg.sv
// ============================================================================
// Module   : bus_datapath_pkg
// Brief    : Shared width and ALU opcode definitions for the bus datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_datapath_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_GPR = 16;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SHR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_ROR = 4'd6,
        ALU_ROL = 4'd7,
        ALU_MUL = 4'd8,
        ALU_DIV = 4'd9,
        ALU_NEG = 4'd10,
        ALU_NOT = 4'd11
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/bus_datapath_alu.sv
// ============================================================================
// Module   : bus_datapath_alu
// Brief    : Combinational ALU, A = Y, B = bus, 64-bit result for Z.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_datapath_alu
    import bus_datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [3:0]          op,
    input  logic                inc,
    output logic [2*DATA_W-1:0] result
);

    logic [4:0]         w_shamt;
    logic [31:0]        w_ror;
    logic [31:0]        w_rol;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic signed [63:0] w_prod;

    assign w_shamt = b[4:0];
    assign w_ror   = (a >> w_shamt) | (a << (6'd32 - {1'b0, w_shamt}));
    assign w_rol   = (a << w_shamt) | (a >> (6'd32 - {1'b0, w_shamt}));
    assign w_prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Divide-by-zero and the single overflowing quotient get fixed results.
    always_comb begin
        w_quot = '1;
        w_rem  = a;
        if (b == '0) begin
            w_quot = '1;
            w_rem  = a;
        end else if (a == 32'h8000_0000 && b == '1) begin
            w_quot = 32'h8000_0000;
            w_rem  = '0;
        end else begin
            w_quot = $signed(a) / $signed(b);
            w_rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        result = '0;
        if (inc) begin
            result = {32'h0, b + 32'd1};
        end else begin
            case (op)
                ALU_AND: result = {32'h0, a & b};
                ALU_OR:  result = {32'h0, a | b};
                ALU_ADD: result = {32'h0, a + b};
                ALU_SUB: result = {32'h0, a - b};
                ALU_SHR: result = {32'h0, a >> w_shamt};
                ALU_SHL: result = {32'h0, a << w_shamt};
                ALU_ROR: result = {32'h0, w_ror};
                ALU_ROL: result = {32'h0, w_rol};
                ALU_MUL: result = w_prod;
                ALU_DIV: result = {w_rem, w_quot};
                ALU_NEG: result = {32'h0, 32'd0 - b};
                ALU_NOT: result = {32'h0, ~b};
                default: result = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_datapath.sv
// ============================================================================
// Module   : bus_datapath
// Brief    : 32-bit single-bus CPU datapath with muxed bus, GPRs and ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_datapath
    import bus_datapath_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_GPR-1:0]  gpr_in,
    input  logic [NUM_GPR-1:0]  gpr_out,
    input  logic                hi_in,
    input  logic                lo_in,
    input  logic                hi_out,
    input  logic                lo_out,
    input  logic                pc_in,
    input  logic                pc_out,
    input  logic                ir_in,
    input  logic                z_in,
    input  logic                z_high_out,
    input  logic                z_low_out,
    input  logic                inport_out,
    input  logic                c_out,
    input  logic                y_in,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                mdr_out,
    input  logic                read,
    input  logic [DATA_W-1:0]   m_data_in,
    input  logic [3:0]          alu_op,
    input  logic                inc_pc,
    output logic [DATA_W-1:0]   bus_data
);

    logic [DATA_W-1:0]   r_gpr [NUM_GPR];
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_inport;
    logic [2*DATA_W-1:0] r_z;

    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_c;
    logic [2*DATA_W-1:0] w_alu;
    logic                w_unused;

    assign w_c      = {{13{r_ir[18]}}, r_ir[18:0]};
    assign bus_data = w_bus;
    // MAR feeds the memory address path outside this block; upper IR is opcode.
    assign w_unused = ^{r_mar, r_ir[31:19]};

    // Sources are applied lowest-priority first so the later match wins.
    always_comb begin
        w_bus = '0;
        if (c_out)      w_bus = w_c;
        if (inport_out) w_bus = r_inport;
        if (mdr_out)    w_bus = r_mdr;
        if (pc_out)     w_bus = r_pc;
        if (z_low_out)  w_bus = r_z[31:0];
        if (z_high_out) w_bus = r_z[63:32];
        if (lo_out)     w_bus = r_lo;
        if (hi_out)     w_bus = r_hi;
        for (int i = NUM_GPR - 1; i >= 0; i--) begin
            if (gpr_out[i]) w_bus = r_gpr[i];
        end
    end

    bus_datapath_alu u_alu (
        .a      (r_y),
        .b      (w_bus),
        .op     (alu_op),
        .inc    (inc_pc),
        .result (w_alu)
    );

    generate
        for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_gpr
            always_ff @(posedge clk) begin
                if (reset_n) begin
                    r_gpr[gi] <= '0;
                end else if (gpr_in[gi]) begin
                    r_gpr[gi] <= w_bus;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_z   <= '0;
        end else begin
            if (pc_in)  r_pc  <= w_bus;
            if (ir_in)  r_ir  <= w_bus;
            if (hi_in)  r_hi  <= w_bus;
            if (lo_in)  r_lo  <= w_bus;
            if (y_in)   r_y   <= w_bus;
            if (mar_in) r_mar <= w_bus;
            if (mdr_in) r_mdr <= read ? m_data_in : w_bus;
            if (z_in)   r_z   <= w_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_inport <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_datapath.sv
// ============================================================================
// Module   : tb_bus_datapath
// Brief    : Directed bench for bus_datapath with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_datapath;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] gpr_in, gpr_out;
    logic        hi_in, lo_in, hi_out, lo_out, pc_in, pc_out, ir_in, z_in;
    logic        z_high_out, z_low_out, inport_out, c_out, y_in, mar_in;
    logic        mdr_in, mdr_out, read, inc_pc;
    logic [31:0] m_data_in;
    logic [3:0]  alu_op;
    logic [31:0] bus_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_datapath dut (
        .clk(clk), .reset_n(reset_n), .gpr_in(gpr_in), .gpr_out(gpr_out),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .z_in(z_in),
        .z_high_out(z_high_out), .z_low_out(z_low_out), .inport_out(inport_out),
        .c_out(c_out), .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .read(read), .m_data_in(m_data_in), .alu_op(alu_op),
        .inc_pc(inc_pc), .bus_data(bus_data)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [16];
    logic [31:0] m_pc, m_ir, m_hi, m_lo, m_y, m_mdr;
    logic [63:0] m_z;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] model_bus();
        logic [31:0] ir_low;
        for (int i = 0; i < 16; i++) if (gpr_out[i]) return m_gpr[i];
        if (hi_out)     return m_hi;
        if (lo_out)     return m_lo;
        if (z_high_out) return m_z[63:32];
        if (z_low_out)  return m_z[31:0];
        if (pc_out)     return m_pc;
        if (mdr_out)    return m_mdr;
        if (inport_out) return 32'h0;
        if (c_out) begin
            ir_low = {13'h0, m_ir[18:0]};
            return m_ir[18] ? (ir_low | 32'hFFF8_0000) : ir_low;
        end
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(logic [31:0] a, logic [31:0] b,
                                              logic [3:0] op, logic inc);
        longint      sa, sb, q, r;
        logic [63:0] aa;
        int          s;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        s  = int'(b[4:0]);
        aa = {a, a};
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            4'd0:  return {32'h0, a & b};
            4'd1:  return {32'h0, a | b};
            4'd2:  return {32'h0, a + b};
            4'd3:  return {32'h0, a - b};
            4'd4:  return {32'h0, a >> s};
            4'd5:  return {32'h0, a << s};
            4'd6:  begin aa = aa >> s; return {32'h0, aa[31:0]}; end
            4'd7:  begin aa = aa << s; return {32'h0, aa[63:32]}; end
            4'd8:  return sa * sb;
            4'd9:  begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa - q * sb;
                return {r[31:0], q[31:0]};
            end
            4'd10: return {32'h0, 32'h0 - b};
            4'd11: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model_update
        logic [31:0] b;
        b = model_bus();
        if (reset_n) begin
            for (int i = 0; i < 16; i++) m_gpr[i] <= '0;
            m_pc <= '0; m_ir <= '0; m_hi <= '0; m_lo <= '0;
            m_y <= '0; m_mdr <= '0; m_z <= '0;
            m_valid <= 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) if (gpr_in[i]) m_gpr[i] <= b;
            if (pc_in)  m_pc  <= b;
            if (ir_in)  m_ir  <= b;
            if (hi_in)  m_hi  <= b;
            if (lo_in)  m_lo  <= b;
            if (y_in)   m_y   <= b;
            if (mdr_in) m_mdr <= read ? m_data_in : b;
            if (z_in)   m_z   <= model_alu(m_y, b, alu_op, inc_pc);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (bus_data !== model_bus()) begin
                errors++;
                $display("FAIL bus_model t=%0t got=%08h exp=%08h", $time, bus_data, model_bus());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        reset_n = 0; gpr_in = '0; gpr_out = '0;
        hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; pc_in = 0; pc_out = 0;
        ir_in = 0; z_in = 0; z_high_out = 0; z_low_out = 0; inport_out = 0;
        c_out = 0; y_in = 0; mar_in = 0; mdr_in = 0; mdr_out = 0; read = 0;
        inc_pc = 0; m_data_in = '0; alu_op = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        #1;
        checks++;
        if (bus_data !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, bus_data, exp);
        end
    endtask

    task automatic mdr_load(input logic [31:0] v);
        clr(); read = 1; mdr_in = 1; m_data_in = v; tick();
    endtask

    task automatic mdr_to_y(input logic [31:0] v);
        mdr_load(v);
        clr(); mdr_out = 1; y_in = 1; tick();
    endtask

    task automatic alu_from_mdr(input logic [31:0] bval, input logic [3:0] op);
        mdr_load(bval);
        clr(); mdr_out = 1; alu_op = op; z_in = 1; tick();
    endtask

    initial begin
        clr(); reset_n = 1; tick();

        for (int i = 0; i < 16; i++) begin
            clr(); gpr_out[i] = 1'b1; lit("reset_gpr", 32'h0);
        end
        clr(); hi_out = 1;     lit("reset_hi", 32'h0);
        clr(); lo_out = 1;     lit("reset_lo", 32'h0);
        clr(); z_high_out = 1; lit("reset_zh", 32'h0);
        clr(); z_low_out = 1;  lit("reset_zl", 32'h0);
        clr(); pc_out = 1;     lit("reset_pc", 32'h0);
        clr(); mdr_out = 1;    lit("reset_mdr", 32'h0);
        clr(); inport_out = 1; lit("reset_inport", 32'h0);
        clr(); c_out = 1;      lit("reset_c", 32'h0);
        clr(); lit("no_source", 32'h0);

        mdr_load(32'h24);
        clr(); mdr_out = 1; gpr_in[2] = 1; lit("mdr_to_r2", 32'h24); tick();
        clr(); gpr_out[2] = 1; lit("r2_out", 32'h24); tick();
        mdr_load(32'h22);
        clr(); mdr_out = 1; gpr_in[4] = 1; tick();

        clr(); pc_out = 1; inc_pc = 1; z_in = 1; alu_op = 4'd2; tick();
        clr(); z_low_out = 1; pc_in = 1; lit("z_inc_pc", 32'h1); tick();
        clr(); pc_out = 1; lit("pc_after_inc", 32'h1); tick();

        clr(); gpr_out[2] = 1; y_in = 1; tick();
        clr(); gpr_out[4] = 1; alu_op = 4'd9; z_in = 1; tick();
        clr(); z_low_out = 1; lo_in = 1; tick();
        clr(); z_high_out = 1; hi_in = 1; tick();
        clr(); lo_out = 1; lit("div_lo", 32'h1);
        clr(); hi_out = 1; lit("div_hi", 32'h2); tick();

        clr(); alu_op = 4'd9; z_in = 1; tick();
        clr(); z_low_out = 1;  lit("div0_q", 32'hFFFF_FFFF);
        clr(); z_high_out = 1; lit("div0_r", 32'h24); tick();

        mdr_to_y(32'hFFFF_FFFE);
        alu_from_mdr(32'h3, 4'd8);
        clr(); z_high_out = 1; lit("mul_hi", 32'hFFFF_FFFF);
        clr(); z_low_out = 1;  lit("mul_lo", 32'hFFFF_FFFA); tick();

        mdr_to_y(32'h5);
        alu_from_mdr(32'h7, 4'd3);
        clr(); z_low_out = 1;  lit("sub_lo", 32'hFFFF_FFFE);
        clr(); z_high_out = 1; lit("sub_hi", 32'h0); tick();

        mdr_to_y(32'h8000_0000);
        alu_from_mdr(32'hFFFF_FFFF, 4'd9);
        clr(); z_low_out = 1;  lit("div_ovf_q", 32'h8000_0000);
        clr(); z_high_out = 1; lit("div_ovf_r", 32'h0); tick();

        mdr_to_y(32'hFFFF_FFF9);
        alu_from_mdr(32'h2, 4'd9);
        clr(); z_low_out = 1;  lit("div_neg_q", 32'hFFFF_FFFD);
        clr(); z_high_out = 1; lit("div_neg_r", 32'hFFFF_FFFF); tick();

        mdr_to_y(32'h8000_00F3);
        for (int op = 0; op < 16; op++) begin
            alu_from_mdr(32'h24, 4'(op));
            clr(); z_low_out = 1;
            if (op == 6) lit("ror4", 32'h3800_000F);
            if (op == 5) lit("shl4", 32'h0000_0F30);
            if (op == 12) lit("op12_zero", 32'h0);
            tick();
            clr(); z_high_out = 1; tick();
        end

        clr(); gpr_out[2] = 1; gpr_out[4] = 1; hi_out = 1; lit("prio_gpr", 32'h24);
        clr(); hi_out = 1; pc_out = 1; lit("prio_hi", 32'h2);
        clr(); pc_out = 1; c_out = 1; mdr_out = 1; lit("prio_pc", 32'h1); tick();

        mdr_load(32'h7920_0000);
        clr(); mdr_out = 1; ir_in = 1; tick();
        clr(); c_out = 1; lit("c_zero", 32'h0); tick();
        mdr_load(32'h0007_FFFF);
        clr(); mdr_out = 1; ir_in = 1; tick();
        clr(); c_out = 1; lit("c_all_ones", 32'hFFFF_FFFF); tick();
        mdr_load(32'h0004_0000);
        clr(); mdr_out = 1; ir_in = 1; tick();
        clr(); c_out = 1; lit("c_sign", 32'hFFFC_0000); tick();

        clr(); gpr_out[2] = 1; gpr_in[2] = 1; y_in = 1; tick();
        clr(); gpr_out[2] = 1; lit("rmw_hold", 32'h24); tick();

        clr(); reset_n = 1; gpr_in = '1; read = 1; mdr_in = 1; m_data_in = 32'hDEAD;
        pc_in = 1; tick();
        clr(); gpr_out[2] = 1; lit("rst_gpr", 32'h0);
        clr(); mdr_out = 1;    lit("rst_mdr", 32'h0);
        clr(); pc_out = 1;     lit("rst_pc", 32'h0); tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
